sp_ram_param: RTL
=================

Name: sp_ram_param

Overview:
Parametrised single-port synchronous RAM that generalises the basic 8-bit-address / 4-bit-data single-port RAM.
- Adds configurable width, depth and read latency, per-lane write enables, and a selectable read-during-write mode.
- Adds a post-reset memory-clear sequencer with a busy flag, plus out-of-range address detection.
- Serves as the storage primitive for buffers and register files elsewhere in the design.

Parameters:
DATA_W, 8, word width in bits; must be a multiple of LANE_W
LANE_W, 4, write-enable granularity in bits; NUM_LANES = DATA_W/LANE_W
ADDR_W, 8, address width
DEPTH, 256, number of words; must satisfy DEPTH <= 2**ADDR_W
RD_LAT, 1, read latency in cycles; legal values are 1 or 2
RDW_MODE, 0, data returned by a write: 0 = read-first (old word), 1 = write-first (merged new word)
INIT_CLEAR, 1, 1 = zero every location after reset; 0 = no clear, ready immediately

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset
en  in  1  access request, sampled at posedge
wr_rd  in  1  1 = write, 0 = read
addr  in  ADDR_W  word address
data_in  in  DATA_W  write data
be  in  NUM_LANES  lane write enables; be[i] covers data_in[i*LANE_W +: LANE_W]
data_out  out  DATA_W  returned word
rd_valid  out  1  one-cycle pulse; data_out is valid in that cycle
addr_err  out  1  one-cycle pulse, aligned with rd_valid, for an out-of-range access
busy  out  1  high while the clear sequencer runs; requests are ignored

Behaviour:
Reset
- rst=0 at posedge: data_out=0, rd_valid=0, addr_err=0, latency pipeline flushed, clear counter=0.
- FSM goes to CLEAR if INIT_CLEAR=1, otherwise to READY. busy=1 during reset when INIT_CLEAR=1.
- Memory contents are not reset directly; only the CLEAR sweep zeroes them.

FSM (2 states)
- CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. After cnt=DEPTH-1 is written, the next state is READY.
- CLEAR takes exactly DEPTH cycles after rst is released; busy=1 throughout. busy falls on the edge that enters READY.
- READY: normal access. busy=0.
- rst=0 in any state, including mid-CLEAR, restarts the sequence from cnt=0.

Access in READY
- An access is accepted when en=1 at a posedge. While busy=1, en is ignored: no write, no rd_valid.
- Read (wr_rd=0): returns mem[addr] with rd_valid=1 exactly RD_LAT cycles after the accepting edge.
- Write (wr_rd=1): updates only the lanes where be[i]=1. be=0 is a legal no-op write that still returns data.
- Every accepted write also returns data with rd_valid after RD_LAT cycles:
  - RDW_MODE=0: the pre-write word.
  - RDW_MODE=1: the merged post-write word.
- Back-to-back accesses on consecutive cycles are fully pipelined. Throughput is 1 access per cycle; rd_valid may stay high continuously.
- A read of an address written on the previous cycle returns the new data; no extra hazard stall.

Data and error outputs
- data_out holds its last value when rd_valid=0. It changes only on valid returns or reset.
- If addr >= DEPTH: the write is suppressed, the read returns 0, and addr_err=1 in the same cycle as rd_valid.
- When DEPTH=2**ADDR_W, addr_err is constant 0.

Timing and widths
- RD_LAT=1: registered memory read.
- RD_LAT=2: adds one output register stage; en/valid/error flags are delayed to match.
- No arithmetic wrap on addr. The clear counter is ADDR_W+1 bits wide so DEPTH=2**ADDR_W terminates correctly.

Test Plan:
Test configuration: DATA_W=8, LANE_W=4, ADDR_W=8, DEPTH=200, RD_LAT=2, RDW_MODE=0, INIT_CLEAR=1.
1. Hold rst=0 for 3 cycles, then release -> busy=1 for exactly 200 cycles, then 0. Read 0x00, 0x63, 0xC7 -> each returns 0x00 with rd_valid 2 cycles after its request.
2. Write 0xAB to 0x10 with be=2'b11, then read 0x10 -> the write returns 0x00 (old word); the read returns 0xAB. Both rd_valid pulses arrive 2 cycles after their requests.
3. Write 0x5C to 0x10 with be=2'b01, then read 0x10 -> read returns 0xAC. Then write 0x00 with be=2'b00 -> location unchanged, still 0xAC.
4. Issue 4 consecutive reads of 0x10, 0x11, 0x10, 0x11 -> rd_valid high for 4 consecutive cycles; data_out = 0xAC, 0x00, 0xAC, 0x00.
5. Write 0xFF to 0xC8 (≥ DEPTH), then read 0xC8 -> addr_err pulses aligned with rd_valid; read returns 0x00; no location is modified (spot-check 0x00 and 0xC7 = 0x00).
6. Assert rst=0 at cnt≈100 during CLEAR, then release -> busy stays high a full 200 cycles from release. A request with en=1 during busy gives no rd_valid and no write.

Source files
------------

// File: rtl/sp_ram_param.sv
// sp_ram_param: parametrised single-port synchronous RAM.
// Per-lane write enables, selectable read-during-write return, read latency of
// 1 or 2 cycles, a post-reset clear sweep with busy flag, and out-of-range
// address detection. Every accepted access (read or write) returns one word.
module sp_ram_param #(
  parameter int DATA_W     = 8,
  parameter int LANE_W     = 4,
  parameter int ADDR_W     = 8,
  parameter int DEPTH      = 256,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       wr_rd,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_in,
  input  logic [DATA_W/LANE_W-1:0]   be,
  output logic [DATA_W-1:0]          data_out,
  output logic                       rd_valid,
  output logic                       addr_err,
  output logic                       busy
);

  localparam int NUM_LANES = DATA_W / LANE_W;
  // One extra bit so that DEPTH == 2**ADDR_W is representable and the sweep
  // terminates cleanly.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             clr_we;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              in_range;
  logic              accept;
  logic              mem_we;
  logic              clr_we_g;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;
  logic [DATA_W-1:0] ret_word;

  logic              s1_valid;
  logic              s1_err;
  logic [DATA_W-1:0] s1_data;

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------

  // State and sweep counter; reset restarts the sweep from location 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_READY;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: sweep one word per cycle, leave CLEAR after the last one.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_IDX) begin
          state_nxt = ST_READY;
          cnt_nxt   = '0;
        end
      end
      ST_READY: begin
        state_nxt = ST_READY;
      end
      default: begin
        state_nxt = ST_READY;
      end
    endcase
  end

  // Requests are ignored while the sweep runs or reset is held.
  assign busy = (state == ST_CLEAR) || ((INIT_CLEAR != 0) && !rst);

  // ---------------------------------------------------------------------------
  // Access path
  // ---------------------------------------------------------------------------

  generate
    if (DEPTH >= (1 << ADDR_W)) begin : g_full_range
      assign in_range = 1'b1;
    end else begin : g_partial_range
      assign in_range = ({1'b0, addr} < CNT_W'(DEPTH));
    end
  endgenerate

  assign accept   = rst && en && (state == ST_READY);
  assign mem_we   = accept && wr_rd && in_range;
  assign clr_we_g = rst && clr_we;

  // Out-of-range addresses never see the array contents.
  assign old_word = in_range ? mem[addr] : '0;

  // Lane merge: enabled lanes take data_in, the rest keep the stored word.
  always_comb begin
    merged_word = old_word;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (be[i]) begin
        merged_word[i*LANE_W +: LANE_W] = data_in[i*LANE_W +: LANE_W];
      end
    end
  end

  // Word returned for this access: old word, or merged word for write-first
  // writes; always zero for an out-of-range address.
  always_comb begin
    ret_word = '0;
    if (in_range) begin
      if (wr_rd && (RDW_MODE != 0)) begin
        ret_word = merged_word;
      end else begin
        ret_word = old_word;
      end
    end
  end

  // Storage array: sweep writes zero, accepted in-range writes store the merge.
  always_ff @(posedge clk) begin
    // NOTE: the array itself has no reset branch so it maps onto RAM macros;
    // its contents are zeroed only by the clear sweep.
    if (clr_we_g) begin
      mem[cnt[ADDR_W-1:0]] <= '0;
    end else if (mem_we) begin
      mem[addr] <= merged_word;
    end
  end

  // First return stage: registered read, valid and error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= accept;
      s1_err   <= accept && !in_range;
      if (accept) begin
        s1_data <= ret_word;
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              s2_valid;
      logic              s2_err;
      logic [DATA_W-1:0] s2_data;

      // Second return stage; data only moves on a valid return so it holds.
      always_ff @(posedge clk) begin
        if (!rst) begin
          s2_valid <= 1'b0;
          s2_err   <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          s2_err   <= s1_err;
          if (s1_valid) begin
            s2_data <= s1_data;
          end
        end
      end

      assign data_out = s2_data;
      assign rd_valid = s2_valid;
      assign addr_err = s2_err;
    end else begin : g_lat1
      assign data_out = s1_data;
      assign rd_valid = s1_valid;
      assign addr_err = s1_err;
    end
  endgenerate

endmodule
